// File: rtl/cclut_rom_scan_ctrl.sv
// cclut_rom_scan_ctrl
//   Shares the two address ports of the CCLUT pattern ROMs between the
//   pattern finder (always wins) and a slow-control scan requester that reads
//   back one selected ROM two words at a time with a running checksum.
//
// Ports
//   clock, reset           system clock, asynchronous active-high reset
//   pf_busy, pf_adr0/1     pattern-finder address request (priority)
//   rom_adr0/1             address to every ROM port 0/1 (combinational mux)
//   rom_sel                pid of the ROM whose data appears on rom_rd0/1
//   rom_rd0/1              read data of ROM rom_sel
//   scan_start/pid/first/last  scan request (sampled in IDLE only)
//   scan_busy              scan in progress
//   scan_valid/ack/data/data_adr  word-pair handshake {word adr+1, word adr}
//   scan_csum              running 16-bit checksum of returned words
//   scan_done, scan_err    one-cycle completion / rejected-request pulses
module cclut_rom_scan_ctrl #(
  parameter int ADRB  = 12,
  parameter int DATB  = 9,
  parameter int NPID  = 5,
  parameter int RDLAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pf_busy,
  input  logic [ADRB-1:0]   pf_adr0,
  input  logic [ADRB-1:0]   pf_adr1,
  output logic [ADRB-1:0]   rom_adr0,
  output logic [ADRB-1:0]   rom_adr1,
  output logic [2:0]        rom_sel,
  input  logic [DATB-1:0]   rom_rd0,
  input  logic [DATB-1:0]   rom_rd1,
  input  logic              scan_start,
  input  logic [2:0]        scan_pid,
  input  logic [ADRB-1:0]   scan_first,
  input  logic [ADRB-1:0]   scan_last,
  output logic              scan_busy,
  output logic              scan_valid,
  input  logic              scan_ack,
  output logic [2*DATB-1:0] scan_data,
  output logic [ADRB-1:0]   scan_data_adr,
  output logic [15:0]       scan_csum,
  output logic              scan_done,
  output logic              scan_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} state_t;

  localparam int CW = (RDLAT > 1) ? $clog2(RDLAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(RDLAT - 1);
  localparam bit SINGLE = (RDLAT == 1);

  state_t          state;
  logic [ADRB-1:0] scan_adr;
  logic [ADRB-1:0] last_adr;
  logic [CW-1:0]   wait_cnt;

  logic            read_done;
  logic [DATB-1:0] pair_hi;
  logic [15:0]     csum_next;
  logic [ADRB:0]   adr_plus2;
  logic            req_ok;

  // Pattern finder passes straight through; scan activity never touches it.
  assign rom_adr0 = pf_busy ? pf_adr0 : scan_adr;
  assign rom_adr1 = pf_busy ? pf_adr1 : scan_adr + ADRB'(1);

  assign req_ok = ({1'b0, scan_pid} < 4'(NPID)) && (scan_first <= scan_last);

  // A read completes at the end of the last window cycle, provided the
  // pattern finder stayed off the ports for the whole window.
  assign read_done = !pf_busy &&
                     ((state == ISSUE && SINGLE) ||
                      (state == WAIT && wait_cnt == WAIT_LAST));

  // Odd-length tail: the word past scan_last is neither returned nor summed.
  assign pair_hi   = (scan_adr == last_adr) ? '0 : rom_rd1;
  assign csum_next = scan_csum + 16'(rom_rd0) + 16'(pair_hi);

  // One extra bit so last_adr = all-ones terminates instead of wrapping.
  assign adr_plus2 = {1'b0, scan_adr} + (ADRB+1)'(2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      scan_adr      <= '0;
      last_adr      <= '0;
      wait_cnt      <= '0;
      rom_sel       <= '0;
      scan_data     <= '0;
      scan_data_adr <= '0;
      scan_csum     <= '0;
      scan_busy     <= 1'b0;
      scan_valid    <= 1'b0;
      scan_done     <= 1'b0;
      scan_err      <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      scan_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_start) begin
            if (req_ok) begin
              rom_sel   <= scan_pid;
              scan_adr  <= scan_first;
              last_adr  <= scan_last;
              scan_csum <= '0;
              scan_busy <= 1'b1;
              state     <= ISSUE;
            end else begin
              scan_err <= 1'b1;
            end
          end
        end
        ISSUE, WAIT: begin
          if (read_done) begin
            scan_data     <= {pair_hi, rom_rd0};
            scan_data_adr <= scan_adr;
            scan_csum     <= csum_next;
            scan_valid    <= 1'b1;
            state         <= HOLD;
          end else if (state == ISSUE) begin
            if (!pf_busy) begin
              wait_cnt <= CW'(1);
              state    <= WAIT;
            end
          end else if (pf_busy) begin
            // Window broken: discard and reissue the same address.
            state <= ISSUE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (scan_ack) begin
            scan_valid <= 1'b0;
            if (adr_plus2 > {1'b0, last_adr}) begin
              scan_done <= 1'b1;
              state     <= DONE;
            end else begin
              scan_adr <= adr_plus2[ADRB-1:0];
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          scan_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cclut_rom_scan_ctrl.sv
// tb_cclut_rom_scan_ctrl
//   Two instances (RDLAT=1 and RDLAT=3) share all stimulus. Each has its own
//   ROM model: the RDLAT=1 model is a falling-edge ROM, the RDLAT=3 model only
//   returns correct data when the address was stable for the whole window.
//   Expected word pairs and checksums come from a list model of each scan.
module tb_cclut_rom_scan_ctrl;

  typedef struct packed {
    logic [11:0] adr;
    logic [17:0] data;
  } beat_t;

  typedef enum int {M_CLEAN, M_TOGGLE, M_GLITCH, M_INTRUDE, M_RANDOM} mode_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        pf_busy;
  logic [11:0] pf_adr0, pf_adr1;
  logic        scan_start;
  logic [2:0]  scan_pid;
  logic [11:0] scan_first, scan_last;
  logic        scan_ack;

  logic [11:0] rom_adr0 [2];
  logic [11:0] rom_adr1 [2];
  logic [2:0]  rom_sel [2];
  logic        scan_busy [2];
  logic        scan_valid [2];
  logic [17:0] scan_data [2];
  logic [11:0] scan_data_adr [2];
  logic [15:0] scan_csum [2];
  logic        scan_done [2];
  logic        scan_err [2];

  logic [8:0]  rd0_a, rd1_a, rd0_b, rd1_b;
  logic [8:0]  mem [8][4096];

  always #5 clock = ~clock;

  cclut_rom_scan_ctrl #(.ADRB(12), .DATB(9), .NPID(5), .RDLAT(1)) dut_lat1 (
    .clock(clock), .reset(reset), .pf_busy(pf_busy),
    .pf_adr0(pf_adr0), .pf_adr1(pf_adr1),
    .rom_adr0(rom_adr0[0]), .rom_adr1(rom_adr1[0]), .rom_sel(rom_sel[0]),
    .rom_rd0(rd0_a), .rom_rd1(rd1_a),
    .scan_start(scan_start), .scan_pid(scan_pid),
    .scan_first(scan_first), .scan_last(scan_last),
    .scan_busy(scan_busy[0]), .scan_valid(scan_valid[0]), .scan_ack(scan_ack),
    .scan_data(scan_data[0]), .scan_data_adr(scan_data_adr[0]),
    .scan_csum(scan_csum[0]), .scan_done(scan_done[0]), .scan_err(scan_err[0])
  );

  cclut_rom_scan_ctrl #(.ADRB(12), .DATB(9), .NPID(5), .RDLAT(3)) dut_lat3 (
    .clock(clock), .reset(reset), .pf_busy(pf_busy),
    .pf_adr0(pf_adr0), .pf_adr1(pf_adr1),
    .rom_adr0(rom_adr0[1]), .rom_adr1(rom_adr1[1]), .rom_sel(rom_sel[1]),
    .rom_rd0(rd0_b), .rom_rd1(rd1_b),
    .scan_start(scan_start), .scan_pid(scan_pid),
    .scan_first(scan_first), .scan_last(scan_last),
    .scan_busy(scan_busy[1]), .scan_valid(scan_valid[1]), .scan_ack(scan_ack),
    .scan_data(scan_data[1]), .scan_data_adr(scan_data_adr[1]),
    .scan_csum(scan_csum[1]), .scan_done(scan_done[1]), .scan_err(scan_err[1])
  );

  // Falling-edge ROM for the RDLAT=1 instance.
  always @(negedge clock) begin
    rd0_a <= mem[rom_sel[0]][rom_adr0[0]];
    rd1_a <= mem[rom_sel[0]][rom_adr1[0]];
  end

  // Three-cycle ROM: corrupt output unless address and pid held for 3 samples.
  logic [11:0] h0 [3];
  logic [11:0] h1 [3];
  logic [2:0]  hs [3];
  logic        stable_b;
  always @(negedge clock) begin
    h0[2] <= h0[1]; h0[1] <= h0[0]; h0[0] <= rom_adr0[1];
    h1[2] <= h1[1]; h1[1] <= h1[0]; h1[0] <= rom_adr1[1];
    hs[2] <= hs[1]; hs[1] <= hs[0]; hs[0] <= rom_sel[1];
  end
  assign stable_b = (h0[0] == h0[1]) && (h0[1] == h0[2]) &&
                    (h1[0] == h1[1]) && (h1[1] == h1[2]) &&
                    (hs[0] == hs[1]) && (hs[1] == hs[2]);
  assign rd0_b = stable_b ? mem[hs[0]][h0[0]] : ~mem[hs[0]][h0[0]];
  assign rd1_b = stable_b ? mem[hs[0]][h1[0]] : ~mem[hs[0]][h1[0]];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt [2] = '{0, 0};
  int err_cnt [2] = '{0, 0};
  int beat_cnt [2] = '{0, 0};
  int rd_idx [2] = '{0, 0};
  int last_beat = -1;
  bit tp_check = 1'b0;
  beat_t exp_q0 [$];
  beat_t exp_q1 [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic beat_t q_at(input int d, input int i);
    return (d == 0) ? exp_q0[i] : exp_q1[i];
  endfunction

  // Per-cycle observation at the falling edge, away from the active edge.
  task automatic sample();
    beat_t b;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        rd_idx[d] = q_size(d);
      end else begin
        if (pf_busy) begin
          check_eq("pf_pass_adr0", 32'(rom_adr0[d]), 32'(pf_adr0));
          check_eq("pf_pass_adr1", 32'(rom_adr1[d]), 32'(pf_adr1));
        end
        if (scan_done[d]) done_cnt[d]++;
        if (scan_err[d]) err_cnt[d]++;
        if (scan_valid[d]) begin
          if (rd_idx[d] >= q_size(d)) begin
            check_eq("beat_extra", 32'(scan_valid[d]), 32'd0);
          end else begin
            b = q_at(d, rd_idx[d]);
            check_eq("beat_data", 32'(scan_data[d]), 32'(b.data));
            check_eq("beat_adr", 32'(scan_data_adr[d]), 32'(b.adr));
            if (scan_ack) begin
              if (d == 0 && tp_check && last_beat >= 0)
                check_eq("beat_gap", 32'(cyc - last_beat), 32'd2);
              if (d == 0) last_beat = cyc;
              rd_idx[d]++;
              beat_cnt[d]++;
            end
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic load_model(input int pid, input int first, input int last,
                            output int nb, output logic [15:0] cs);
    beat_t b;
    logic [8:0] lo, hi;
    nb = 0;
    cs = '0;
    for (int a = first; a <= last; a += 2) begin
      lo = mem[pid][a];
      hi = (a == last) ? 9'd0 : mem[pid][a + 1];
      b.adr  = 12'(a);
      b.data = {hi, lo};
      cs = cs + 16'(lo) + 16'(hi);
      exp_q0.push_back(b);
      exp_q1.push_back(b);
      nb++;
    end
  endtask

  task automatic drive(input mode_t mode, input int c);
    case (mode)
      M_CLEAN:  begin pf_busy = 1'b0; scan_ack = 1'b1; end
      M_TOGGLE: begin pf_busy = (c < 16) && (c % 2 == 0); scan_ack = 1'b1; end
      M_GLITCH: begin pf_busy = (c == 1); scan_ack = 1'b1; end
      M_INTRUDE: begin
        pf_busy    = 1'b0;
        scan_ack   = 1'b1;
        scan_start = (c == 1);
        if (c == 1) begin
          scan_pid   = 3'd3;
          scan_first = 12'h200;
          scan_last  = 12'h2FF;
        end
      end
      default: begin
        pf_busy  = ($urandom_range(3) == 0);
        pf_adr0  = 12'($urandom);
        pf_adr1  = 12'($urandom);
        scan_ack = ($urandom_range(2) != 0);
      end
    endcase
  endtask

  task automatic start_pulse(input int pid, input int first, input int last);
    scan_pid   = 3'(pid);
    scan_first = 12'(first);
    scan_last  = 12'(last);
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
  endtask

  task automatic run_scan(input string tag, input int pid, input int first,
                          input int last, input mode_t mode, output logic [15:0] cs);
    int nb;
    int done0 [2];
    int err0 [2];
    int beat0 [2];
    load_model(pid, first, last, nb, cs);
    for (int d = 0; d < 2; d++) begin
      done0[d] = done_cnt[d]; err0[d] = err_cnt[d]; beat0[d] = beat_cnt[d];
    end
    start_pulse(pid, first, last);
    for (int c = 0; c < 3000; c++) begin
      drive(mode, c);
      step();
      if (done_cnt[0] > done0[0] && done_cnt[1] > done0[1]) break;
    end
    scan_ack = 1'b0; pf_busy = 1'b0; scan_start = 1'b0;
    repeat (4) step();
    for (int d = 0; d < 2; d++) begin
      check_eq({tag, "_done"}, 32'(done_cnt[d] - done0[d]), 32'd1);
      check_eq({tag, "_err"}, 32'(err_cnt[d] - err0[d]), 32'd0);
      check_eq({tag, "_beats"}, 32'(beat_cnt[d] - beat0[d]), 32'(nb));
      check_eq({tag, "_left"}, 32'(q_size(d) - rd_idx[d]), 32'd0);
      check_eq({tag, "_csum"}, 32'(scan_csum[d]), 32'(cs));
      check_eq({tag, "_busy"}, 32'(scan_busy[d]), 32'd0);
    end
  endtask

  task automatic bad_start(input string tag, input int pid, input int first, input int last);
    int done0 [2];
    int err0 [2];
    for (int d = 0; d < 2; d++) begin done0[d] = done_cnt[d]; err0[d] = err_cnt[d]; end
    start_pulse(pid, first, last);
    repeat (4) begin
      step();
      for (int d = 0; d < 2; d++) check_eq({tag, "_busy"}, 32'(scan_busy[d]), 32'd0);
    end
    for (int d = 0; d < 2; d++) begin
      check_eq({tag, "_err"}, 32'(err_cnt[d] - err0[d]), 32'd1);
      check_eq({tag, "_done"}, 32'(done_cnt[d] - done0[d]), 32'd0);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq({tag, "_busy"}, 32'(scan_busy[d]), 32'd0);
      check_eq({tag, "_valid"}, 32'(scan_valid[d]), 32'd0);
      check_eq({tag, "_data"}, 32'(scan_data[d]), 32'd0);
      check_eq({tag, "_dadr"}, 32'(scan_data_adr[d]), 32'd0);
      check_eq({tag, "_csum"}, 32'(scan_csum[d]), 32'd0);
      check_eq({tag, "_done"}, 32'(scan_done[d]), 32'd0);
      check_eq({tag, "_err"}, 32'(scan_err[d]), 32'd0);
      check_eq({tag, "_sel"}, 32'(rom_sel[d]), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] cs;
    int nb;
    int done0 [2];
    int pid, first, last;

    for (int p = 0; p < 8; p++)
      for (int a = 0; a < 4096; a++)
        mem[p][a] = (p == 2) ? 9'(a) : ((p < 5) ? 9'($urandom) : 9'd0);

    reset = 1'b1; pf_busy = 1'b0; pf_adr0 = 12'h7AB; pf_adr1 = 12'h3C5;
    scan_start = 1'b0; scan_pid = '0; scan_first = '0; scan_last = '0; scan_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_zero_outputs("rst");
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_adr0", 32'(rom_adr0[d]), 32'h000);
      check_eq("rst_adr1", 32'(rom_adr1[d]), 32'h001);
    end
    reset = 1'b0;
    step();

    // Back-to-back pairs at full rate.
    tp_check = 1'b1;
    run_scan("s1", 2, 12'h010, 12'h013, M_CLEAN, cs);
    tp_check = 1'b0;
    for (int d = 0; d < 2; d++) check_eq("s1_csum_abs", 32'(scan_csum[d]), 32'h046);

    // Odd-length tail masks the high word.
    run_scan("s2", 2, 12'h020, 12'h022, M_CLEAN, cs);
    for (int d = 0; d < 2; d++) check_eq("s2_csum_abs", 32'(scan_csum[d]), 32'h063);

    run_scan("s3", 2, 12'h010, 12'h013, M_TOGGLE, cs);
    run_scan("s4", 2, 12'h010, 12'h013, M_GLITCH, cs);
    for (int d = 0; d < 2; d++) check_eq("s4_csum_abs", 32'(scan_csum[d]), 32'h046);

    bad_start("bad_pid", 5, 12'h000, 12'h001);
    bad_start("bad_rng", 1, 12'h100, 12'h0FF);
    run_scan("s5", 1, 12'h080, 12'h09F, M_INTRUDE, cs);

    // Hold without ack, then reset in the middle of the hold.
    load_model(3, 12'h040, 12'h047, nb, cs);
    for (int d = 0; d < 2; d++) done0[d] = done_cnt[d];
    scan_ack = 1'b0; pf_busy = 1'b0;
    start_pulse(3, 12'h040, 12'h047);
    repeat (4) step();
    repeat (10) begin
      step();
      for (int d = 0; d < 2; d++) check_eq("hold_valid", 32'(scan_valid[d]), 32'd1);
    end
    reset = 1'b1;
    #1;
    check_zero_outputs("midrst");
    step();
    reset = 1'b0;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      check_eq("midrst_nodone", 32'(done_cnt[d] - done0[d]), 32'd0);
      check_eq("midrst_idle", 32'(scan_busy[d]), 32'd0);
    end

    run_scan("s6a", 3, 12'h040, 12'h047, M_CLEAN, cs);
    run_scan("s6b", 4, 12'hFFE, 12'hFFF, M_CLEAN, cs);
    run_scan("s6c", 4, 12'hFFF, 12'hFFF, M_CLEAN, cs);
    run_scan("s6d", 0, 12'h000, 12'h000, M_RANDOM, cs);

    for (int i = 0; i < 16; i++) begin
      pid   = $urandom_range(4);
      first = $urandom_range(4095);
      last  = first + $urandom_range(23);
      if (last > 4095) last = 4095;
      run_scan("rnd", pid, first, last, M_RANDOM, cs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cclut_rom_scan_ctrl.md
Name: cclut_rom_scan_ctrl

Overview:
- Shares the address ports of the five CCLUT pattern ROMs (pid 0..4, 9-bit words: [4:0] bend, [8:5] offset) between the pattern finder and a slow-control readback requester.
- The pattern finder always has priority.
- The requester can scan any address range of one selected ROM. Words come back two at a time through a valid/ack handshake, with a running checksum for firmware-image verification.

Parameters:
ADRB, 12, ROM address width (comparator-code width)
DATB, 9, ROM data width
NPID, 5, number of CCLUT ROMs (valid pid 0..NPID-1)
RDLAT, 1, ROM read latency in clocks (falling-edge ROM gives 1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
pf_busy  in  1  pattern finder drives ROM addresses this cycle
pf_adr0  in  ADRB  pattern-finder port-0 address
pf_adr1  in  ADRB  pattern-finder port-1 address
rom_adr0  out  ADRB  address to all ROM port 0
rom_adr1  out  ADRB  address to all ROM port 1
rom_sel  out  3  pid of ROM whose data is returned on rom_rd0/1
rom_rd0  in  DATB  port-0 read data of ROM rom_sel
rom_rd1  in  DATB  port-1 read data of ROM rom_sel
scan_start  in  1  request a scan (sampled in IDLE only)
scan_pid  in  3  ROM to scan
scan_first  in  ADRB  first address
scan_last  in  ADRB  last address, inclusive
scan_busy  out  1  scan in progress
scan_valid  out  1  scan_data holds an unacknowledged word pair
scan_ack  in  1  consumer accepts scan_data
scan_data  out  2*DATB  {word at adr+1, word at adr}
scan_data_adr  out  ADRB  address of the low word
scan_csum  out  16  running checksum
scan_done  out  1  one-cycle pulse at scan completion
scan_err  out  1  one-cycle pulse on a rejected request

Behaviour:
- rom_adr0/1 are a combinational mux:
  - pf_busy=1: pf_adr0/1 pass through unconditionally.
  - pf_busy=0: scan_adr and scan_adr+1 (mod 2^ADRB).
- rom_sel is the registered scan_pid.
- Reset (async, any state) sets:
  - state=IDLE
  - scan_adr, rom_sel, scan_data, scan_data_adr, scan_csum = 0
  - scan_busy, scan_valid, scan_done, scan_err = 0
  - An interrupted scan is abandoned, with no done pulse.
- FSM states are IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE:
  - scan_start=1 with scan_pid<NPID and scan_first<=scan_last: latch pid, first and last, clear scan_csum, set scan_busy, go to ISSUE.
  - Otherwise, scan_start=1 gives a scan_err pulse on the next cycle and the FSM stays in IDLE.
  - scan_start outside IDLE is ignored.
- ISSUE:
  - The issue cycle t is the first cycle with pf_busy=0.
  - Read window = cycles t..t+RDLAT-1. pf_busy must stay 0 for the whole window.
  - If pf_busy rises inside the window, the read is discarded and the FSM returns to ISSUE to reissue the same address.
  - With RDLAT=1 there is no WAIT state. Data is sampled at the rising edge ending cycle t.
- Capture:
  - scan_data[DATB-1:0] = rom_rd0.
  - scan_data[2*DATB-1:DATB] = rom_rd1, or 0 when scan_adr = scan_last (odd-length tail).
  - scan_data_adr = scan_adr.
  - scan_csum += rom_rd0, plus rom_rd1 unless masked; words are zero-extended and the sum wraps mod 2^16.
  - scan_valid=1 and the FSM goes to HOLD.
- HOLD:
  - scan_data, scan_data_adr and scan_valid hold until scan_ack=1; scan_ack is ignored while scan_valid=0.
  - On ack, scan_valid is cleared in the next cycle.
  - Compare uses ADRB+1 bits so that scan_last = 2^ADRB-1 terminates without wrap.
  - If scan_adr+2 > scan_last: go to DONE.
  - Otherwise scan_adr += 2 and go to ISSUE.
  - Earliest new issue is the cycle after the ack.
- DONE:
  - One-cycle scan_done pulse, then scan_busy=0 and back to IDLE.
  - scan_csum holds its final value until the next accepted start.
- Throughput with pf_busy=0, RDLAT=1 and ack asserted immediately: one word pair per 2 cycles.
- The pattern-finder path is never delayed or modified by scan activity.

Test Plan:
1. Reset, pf_busy=0, ROM pid 2 preloaded with word = address[8:0]. Start pid=2, first=0x010, last=0x013, ack tied 1 -> scan_data = {0x011,0x010} then {0x013,0x012}, scan_data_adr 0x010/0x012, scan_done one cycle, scan_csum = 0x046.
2. Same ROM, first=0x020, last=0x022 -> second pair is {0x000,0x022}, scan_csum = 0x063, exactly 2 valid beats.
3. pf_busy toggling 1,0,1,0... with pf_adr0=0x7AB -> rom_adr0=0x7AB on every pf_busy=1 cycle; scan data still matches scenario 1 values.
4. Set RDLAT=3 and assert pf_busy for one cycle at t+1 of an issue -> read is discarded and reissued, no duplicate or missing beat, csum unchanged versus scenario 1.
5. Start with pid=5, then start with first=0x100, last=0x0FF -> scan_err pulses once each, scan_busy stays 0. Start during an active scan -> ignored.
6. Hold ack=0 for 10 cycles -> scan_data stable and scan_valid=1. Assert reset mid-HOLD -> all outputs 0 immediately, no scan_done. New scan then runs normally. Scan of last=0xFFF, first=0xFFE -> single pair, terminates.
